// File: rtl/sr_ff_bank.sv
// Bank of clocked set/reset flip-flops with compile-time s=r=1 resolution,
// per-channel change pulses, sticky conflict flags and a saturating conflict counter.
module sr_ff_bank #(
  parameter int unsigned     WIDTH = 4,
  parameter int unsigned     MODE  = 0,
  parameter int unsigned     CNT_W = 8,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] chg,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Out-of-range modes fold onto hold.
  localparam int unsigned ModeEff = (MODE > 3) ? 0 : MODE;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic [WIDTH-1:0] conflict_q, conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] both;
  logic [WIDTH-1:0] q_both;
  logic [WIDTH-1:0] q_sr;

  assign both = s & r;

  always_comb begin
    q_both = q_q;
    case (ModeEff)
      1:       q_both = '1;
      2:       q_both = '0;
      3:       q_both = ~q_q;
      default: q_both = q_q;
    endcase
  end

  // Non-conflicting channels: set wins over hold, reset wins over hold.
  assign q_sr = (q_q | s) & ~r;

  always_comb begin
    q_d        = q_q;
    chg_d      = '0;
    conflict_d = clr_conflict ? '0 : conflict_q;
    cnt_d      = clr_conflict ? '0 : cnt_q;
    if (en) begin
      q_d        = (both & q_both) | (~both & q_sr);
      chg_d      = q_d ^ q_q;
      conflict_d = conflict_d | both;
      // A clear on the same edge is applied first so the new event is counted.
      if (|both && (cnt_d != CntMax)) begin
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q        <= INIT;
      chg_q      <= '0;
      conflict_q <= '0;
      cnt_q      <= '0;
    end else begin
      q_q        <= q_d;
      chg_q      <= chg_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign q            = q_q;
  assign qbar         = ~q_q;
  assign chg          = chg_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed self-checking bench for sr_ff_bank: a toggle-mode main instance plus
// a sweep of all MODE values with a 2-bit counter sharing one stimulus set.
module tb_sr_ff_bank;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst = 1'b0;

  always #5 if (clk_run) clk = ~clk;

  // Main instance: MODE 3, INIT 0101.
  logic       a_en, a_clr;
  logic [3:0] a_s, a_r;
  logic [3:0] a_q, a_qbar, a_chg, a_conflict;
  logic [7:0] a_cnt;

  sr_ff_bank #(.WIDTH(4), .MODE(3), .CNT_W(8), .INIT(4'b0101)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (a_en),
    .s            (a_s),
    .r            (a_r),
    .clr_conflict (a_clr),
    .q            (a_q),
    .qbar         (a_qbar),
    .chg          (a_chg),
    .conflict     (a_conflict),
    .conflict_cnt (a_cnt)
  );

  // Sweep instances: MODE 0..4, CNT_W 2, INIT 0001.
  logic       b_en, b_clr;
  logic [3:0] b_s, b_r;
  logic [3:0] b_q [5];
  logic [3:0] b_qbar [5];
  logic [3:0] b_chg [5];
  logic [3:0] b_conflict [5];
  logic [1:0] b_cnt [5];

  for (genvar g = 0; g < 5; g++) begin : g_sweep
    sr_ff_bank #(.WIDTH(4), .MODE(g), .CNT_W(2), .INIT(4'b0001)) dut_m (
      .clk          (clk),
      .rst          (rst),
      .en           (b_en),
      .s            (b_s),
      .r            (b_r),
      .clr_conflict (b_clr),
      .q            (b_q[g]),
      .qbar         (b_qbar[g]),
      .chg          (b_chg[g]),
      .conflict     (b_conflict[g]),
      .conflict_cnt (b_cnt[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-MODE results of one s=r=0001 edge from q=0001.
  logic [3:0] sweep_q   [5] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
  logic [3:0] sweep_chg [5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};

  initial begin
    a_en = 1'b1; a_clr = 1'b0; a_s = '0; a_r = '0;
    b_en = 1'b1; b_clr = 1'b0; b_s = '0; b_r = '0;

    // Async reset with the clock stopped.
    #2 rst = 1'b1;
    #1;
    chk("rst_q",        a_q, 4'b0101);
    chk("rst_qbar",     a_qbar, 4'b1010);
    chk("rst_chg",      a_chg, 4'b0000);
    chk("rst_conflict", a_conflict, 4'b0000);
    chk("rst_cnt",      a_cnt, 8'd0);
    chk("rst_b_q",      b_q[3], 4'b0001);

    clk_run = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Basic SR.
    a_s = 4'b0010; a_r = 4'b0100;
    step();
    chk("sr_q",    a_q, 4'b0011);
    chk("sr_qbar", a_qbar, 4'b1100);
    chk("sr_chg",  a_chg, 4'b0110);
    a_s = '0; a_r = '0;
    step();
    chk("hold_q",   a_q, 4'b0011);
    chk("hold_chg", a_chg, 4'b0000);

    // MODE sweep.
    b_s = 4'b0001; b_r = 4'b0001;
    step();
    for (int m = 0; m < 5; m++) begin
      chk($sformatf("sweep_q_m%0d", m),        b_q[m], sweep_q[m]);
      chk($sformatf("sweep_chg_m%0d", m),      b_chg[m], sweep_chg[m]);
      chk($sformatf("sweep_conflict_m%0d", m), b_conflict[m], 4'b0001);
      chk($sformatf("sweep_cnt_m%0d", m),      b_cnt[m], 2'd1);
    end

    // Saturation of a 2-bit counter: 5 conflicting edges in total.
    repeat (4) step();
    chk("sat_cnt_m0", b_cnt[0], 2'd3);
    chk("sat_cnt_m3", b_cnt[3], 2'd3);

    // Clear colliding with a new conflict on a different channel.
    b_clr = 1'b1; b_s = 4'b1000; b_r = 4'b1000;
    step();
    chk("clrcol_conflict", b_conflict[0], 4'b1000);
    chk("clrcol_cnt",      b_cnt[0], 2'd1);
    b_s = '0; b_r = '0;
    step();
    chk("clr_conflict", b_conflict[0], 4'b0000);
    chk("clr_cnt",      b_cnt[0], 2'd0);
    b_clr = 1'b0;

    // Toggle mode from q=0000.
    a_r = 4'b1111;
    step();
    chk("pre_tog_q", a_q, 4'b0000);
    a_s = 4'b1111;
    step();
    chk("tog1_q", a_q, 4'b1111);
    chk("tog1_chg", a_chg, 4'b1111);
    step();
    chk("tog2_q", a_q, 4'b0000);
    chk("tog2_chg", a_chg, 4'b1111);
    step();
    chk("tog3_q", a_q, 4'b1111);
    chk("tog3_chg", a_chg, 4'b1111);
    chk("tog3_cnt", a_cnt, 8'd3);
    chk("tog3_conflict", a_conflict, 4'b1111);
    step();
    chk("tog4_q", a_q, 4'b0000);
    chk("tog4_cnt", a_cnt, 8'd4);

    // Enable gating.
    a_en = 1'b0; a_s = 4'b1111; a_r = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("gate_q_%0d", k),   a_q, 4'b0000);
      chk($sformatf("gate_chg_%0d", k), a_chg, 4'b0000);
    end
    chk("gate_cnt_hold", a_cnt, 8'd4);
    a_s = '0; a_clr = 1'b1;
    step();
    chk("gate_clr_conflict", a_conflict, 4'b0000);
    chk("gate_clr_cnt",      a_cnt, 8'd0);
    a_clr = 1'b0; a_s = 4'b1111; a_r = 4'b1111;
    step();
    chk("gate_noconf_conflict", a_conflict, 4'b0000);
    chk("gate_noconf_cnt",      a_cnt, 8'd0);
    chk("gate_noconf_q",        a_q, 4'b0000);

    // Async reset between edges while toggling.
    a_en = 1'b1;
    step();
    chk("pre_rst_q", a_q, 4'b1111);
    chk("pre_rst_cnt", a_cnt, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_q",        a_q, 4'b0101);
    chk("midrst_chg",      a_chg, 4'b0000);
    chk("midrst_conflict", a_conflict, 4'b0000);
    chk("midrst_cnt",      a_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    a_s = '0; a_r = '0;
    step();
    chk("post_rst_q",   a_q, 4'b0101);
    chk("post_rst_chg", a_chg, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
